crc24a_attach: RTL and testbench
================================

Name: crc24a_attach

Overview:
- Upstream stage of the turbo interleaver FSM. Accepts a serial payload bit stream and computes LTE CRC-24A over it.
- Emits the gapless K-bit block (payload followed by 24 parity bits) on the interleaver's CRC_start / CRC_data / block_size inputs, timed to the FSM's idle→start→write sequence.
- Does not start the next block until the interleaver signals done.

Parameters:
- K_SMALL, 1056, total output bits (payload + 24 CRC) when block_size_in=0
- K_LARGE, 6144, total output bits when block_size_in=1
- POLY, 24'h864CFB, CRC-24A generator, x^24 term implicit
- END_PULSE_EN, 0, 1 = pulse CRC_END on last parity bit; 0 = CRC_END tied low

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  payload bit valid
- in_data  in  1  payload bit
- in_sof  in  1  first bit of a frame, qualified by in_valid
- block_size_in  in  1  0 = K_SMALL, 1 = K_LARGE; sampled with in_sof
- in_ready  out  1  payload bit consumed this cycle when in_valid & in_ready
- ilv_done  in  1  interleaver done pulse
- CRC_start  out  1  one-cycle frame start to interleaver
- CRC_data  out  1  serial output bit
- CRC_END  out  1  see END_PULSE_EN
- block_size  out  1  registered size, held for the whole frame
- data_valid  out  1  high while CRC_data carries a block bit
- busy  out  1  high in every state except IDLE
- err_underrun  out  1  sticky; cleared on the next accepted in_sof
- err_sof  out  1  sticky; in_sof seen mid-payload; cleared on the next accepted in_sof

Behaviour:
- Reset (asynchronous, active-high): state=IDLE. All outputs 0, CRC register 0, counters 0.
- All outputs are registered.
- States: IDLE, START, GAP, PAYLOAD, PARITY, WAIT_DONE.
- IDLE:
  - in_ready=0; the peeked in_valid & in_sof bit is not consumed.
  - On in_valid & in_sof: latch block_size_in into block_size, clear err flags, clear CRC and bit counter, go to START.
- START: CRC_start=1 for exactly this cycle (c0). Go to GAP.
- GAP (c1): in_ready=1, so the first payload bit is consumed here. Go to PAYLOAD.
- Output timing:
  - A bit consumed in cycle t appears on CRC_data in cycle t+1 with data_valid=1.
  - Payload bit i appears at c2+i.
  - in_ready is high for exactly P=K-24 consecutive cycles, c1..c1+P-1.
- Underrun:
  - Condition: in_ready=1 with in_valid=0.
  - Bit 0 is substituted and counted, so the stream stays gapless and the interleaver counters stay aligned.
  - err_underrun is set; the CRC covers the substituted 0.
- in_sof on any consumed bit other than the first: bit treated as ordinary data, err_sof set.
- CRC register:
  - Galois LFSR: fb = crc[23]^bit; crc = {crc[22:0],1'b0} ^ (fb ? POLY : 0).
  - Init 0, no reflection, no final XOR; updated on every consumed/substituted payload bit.
- PARITY:
  - Entered after the P-th payload bit is consumed.
  - Emits crc[23] first through crc[0] on 24 consecutive cycles c2+P..c2+K-1, data_valid=1, in_ready=0.
  - CRC_END pulses on the last parity bit iff END_PULSE_EN=1.
- Bit counter: 13 bits wide, sized for K_LARGE; compares against K-1 of the latched size. No wrap within a frame.
- WAIT_DONE:
  - data_valid=0, in_ready=0.
  - On ilv_done go to IDLE; the earliest new START is the cycle after IDLE, matching the interleaver's return to idle.
- ilv_done in any state other than WAIT_DONE is ignored.
- Reset mid-frame: immediate abort to IDLE, outputs 0, partial frame discarded.
- block_size is constant from START through WAIT_DONE.

Test Plan:
- K_SMALL=32, block_size_in=0, payload 8'b10000000 (MSB first), no gaps -> CRC_start at c0; CRC_data c2..c9 = payload; c10..c33 = 24'h3347A4 MSB first; data_valid high exactly c2..c33.
- Default params, block_size_in=1, 6120 zero bits -> 6144 output bits all 0; in_ready high for 6120 cycles; block_size=1 held; busy until ilv_done.
- Random 1032-bit payload, block_size_in=0 -> parity equals the software CRC-24A model; running the model over all 1056 output bits gives remainder 0.
- K_SMALL=32, in_valid dropped for payload bit 3 -> bit 3 emitted as 0, err_underrun=1, parity matches the model over the substituted stream, total length still 32.
- Frame in_sof held while in WAIT_DONE, ilv_done pulsed at cycle n -> IDLE at n+1, CRC_start at n+2 earliest; earlier ilv_done pulses ignored.
- reset asserted mid-PAYLOAD -> same cycle: outputs 0, busy=0; next frame after release produces the correct CRC.

Source files
------------

// File: rtl/crc24a_attach.sv
// crc24a_attach
//   Appends an LTE CRC-24A to a serial payload and feeds the result to the
//   turbo interleaver as one gapless K-bit block (payload then 24 parity
//   bits). The block follows the interleaver's idle -> start -> write order,
//   and the next block is held off until the interleaver reports done.
//
//   Handshake: a payload bit moves on a rising edge when in_ready is high.
//   If in_valid is high on that edge, in_data is taken. If in_valid is low,
//   a 0 is inserted in its place and err_underrun is set, so the block keeps
//   its length. While in_ready is low nothing is taken. In IDLE the DUT only
//   looks at in_valid & in_sof to start a frame. That first bit stays on the
//   inputs and is taken later, in GAP.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   in_valid/in_data  serial payload bit
//   in_sof            first bit of a frame (only counts with in_valid)
//   block_size_in     0 = K_SMALL, 1 = K_LARGE, sampled together with in_sof
//   in_ready          high in a cycle where a payload bit is taken
//   ilv_done          interleaver done pulse (only used in WAIT_DONE)
//   CRC_start         one-cycle frame start
//   CRC_data          serial block bit, qualified by data_valid
//   CRC_END           pulse on the last parity bit when END_PULSE_EN = 1
//   block_size        size latched at frame start
//   data_valid        CRC_data carries a block bit
//   busy              state is not IDLE
//   err_underrun      sticky, a 0 was inserted for a missing bit
//   err_sof           sticky, in_sof seen on a payload bit after the first
//   dbg_state         current FSM state
module crc24a_attach #(
   parameter int unsigned K_SMALL      = 1056,
   parameter int unsigned K_LARGE      = 6144,
   parameter logic [23:0] POLY         = 24'h864CFB,
   parameter bit          END_PULSE_EN = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic       in_data,
   input  logic       in_sof,
   input  logic       block_size_in,
   output logic       in_ready,
   input  logic       ilv_done,
   output logic       CRC_start,
   output logic       CRC_data,
   output logic       CRC_END,
   output logic       block_size,
   output logic       data_valid,
   output logic       busy,
   output logic       err_underrun,
   output logic       err_sof,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_START     = 3'd1,
      S_GAP       = 3'd2,
      S_PAYLOAD   = 3'd3,
      S_PARITY    = 3'd4,
      S_WAIT_DONE = 3'd5
   } state_t;

   localparam logic [12:0] LAST_S = 13'(K_SMALL - 1);
   localparam logic [12:0] LAST_L = 13'(K_LARGE - 1);

   state_t      r_state, w_next_state;
   logic [12:0] r_cnt, w_cnt;      // index of the next block bit to load
   logic [23:0] r_crc, w_crc;
   logic        r_in_ready, w_in_ready;
   logic        r_crc_start, w_crc_start;
   logic        r_data, w_data;
   logic        r_end, w_end;
   logic        r_bsize, w_bsize;
   logic        r_valid, w_valid;
   logic        r_busy, w_busy;
   logic        r_err_under, w_err_under;
   logic        r_err_sof, w_err_sof;

   logic [12:0] w_last_idx;        // K-1 for the latched size
   logic [12:0] w_last_pay;        // K-25: index of the last payload bit
   logic        w_bit;             // a missing bit is replaced by 0
   logic        w_fb;
   logic [23:0] w_crc_upd;

   assign w_last_idx = r_bsize ? LAST_L : LAST_S;
   assign w_last_pay = w_last_idx - 13'd24;
   assign w_bit      = in_valid & in_data;
   assign w_fb       = r_crc[23] ^ w_bit;
   assign w_crc_upd  = {r_crc[22:0], 1'b0} ^ (w_fb ? POLY : 24'h000000);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next_state;
   end

   // Each output register is loaded with the value it should show in the
   // next cycle, so every port comes straight from a flop.
   always_comb begin
      w_next_state = r_state;
      w_cnt        = r_cnt;
      w_crc        = r_crc;
      w_in_ready   = 1'b0;
      w_crc_start  = 1'b0;
      w_data       = 1'b0;
      w_valid      = 1'b0;
      w_end        = 1'b0;
      w_bsize      = r_bsize;
      w_err_under  = r_err_under;
      w_err_sof    = r_err_sof;
      case (r_state)
         S_IDLE: begin
            if (in_valid && in_sof) begin
               w_next_state = S_START;
               w_crc_start  = 1'b1;
               w_bsize      = block_size_in;
               w_err_under  = 1'b0;
               w_err_sof    = 1'b0;
               w_crc        = 24'h000000;
               w_cnt        = 13'd0;
            end
         end
         S_START: begin
            w_next_state = S_GAP;
            w_in_ready   = 1'b1;
         end
         S_GAP, S_PAYLOAD: begin
            // in_ready is high in both states, so a bit is taken every cycle.
            w_data  = w_bit;
            w_valid = 1'b1;
            w_crc   = w_crc_upd;
            w_cnt   = r_cnt + 13'd1;
            if (!in_valid) w_err_under = 1'b1;
            if (in_valid && in_sof && (r_cnt != 13'd0)) w_err_sof = 1'b1;
            if (r_cnt == w_last_pay) begin
               w_next_state = S_PARITY;
            end else begin
               w_next_state = S_PAYLOAD;
               w_in_ready   = 1'b1;
            end
         end
         S_PARITY: begin
            // The CRC register shifts out MSB first. The parity is final at
            // this point because the last payload bit was already folded in.
            w_data  = r_crc[23];
            w_valid = 1'b1;
            w_crc   = {r_crc[22:0], 1'b0};
            w_cnt   = r_cnt + 13'd1;
            if (r_cnt == w_last_idx) begin
               w_next_state = S_WAIT_DONE;
               w_end        = END_PULSE_EN;
            end
         end
         S_WAIT_DONE: begin
            if (ilv_done) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
      w_busy = (w_next_state != S_IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt       <= 13'd0;
         r_crc       <= 24'h000000;
         r_in_ready  <= 1'b0;
         r_crc_start <= 1'b0;
         r_data      <= 1'b0;
         r_end       <= 1'b0;
         r_bsize     <= 1'b0;
         r_valid     <= 1'b0;
         r_busy      <= 1'b0;
         r_err_under <= 1'b0;
         r_err_sof   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt;
         r_crc       <= w_crc;
         r_in_ready  <= w_in_ready;
         r_crc_start <= w_crc_start;
         r_data      <= w_data;
         r_end       <= w_end;
         r_bsize     <= w_bsize;
         r_valid     <= w_valid;
         r_busy      <= w_busy;
         r_err_under <= w_err_under;
         r_err_sof   <= w_err_sof;
      end
   end

   assign in_ready     = r_in_ready;
   assign CRC_start    = r_crc_start;
   assign CRC_data     = r_data;
   assign CRC_END      = r_end;
   assign block_size   = r_bsize;
   assign data_valid   = r_valid;
   assign busy         = r_busy;
   assign err_underrun = r_err_under;
   assign err_sof      = r_err_sof;
   assign dbg_state    = r_state;

endmodule

// File: tb/tb_crc24a_attach.sv
module tb_crc24a_attach;

   localparam int KS = 32;
   localparam int KL = 6144;
   localparam logic [23:0] POLY = 24'h864CFB;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid, in_data, in_sof, block_size_in, ilv_done;
   logic       in_ready, CRC_start, CRC_data, CRC_END, block_size;
   logic       data_valid, busy, err_underrun, err_sof;
   logic [2:0] dbg_state;

   crc24a_attach #(
      .K_SMALL(KS), .K_LARGE(KL), .POLY(POLY), .END_PULSE_EN(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
      .in_sof(in_sof), .block_size_in(block_size_in), .in_ready(in_ready),
      .ilv_done(ilv_done), .CRC_start(CRC_start), .CRC_data(CRC_data),
      .CRC_END(CRC_END), .block_size(block_size), .data_valid(data_valid),
      .busy(busy), .err_underrun(err_underrun), .err_sof(err_sof),
      .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc_abs = 0;
   always @(negedge clk) cyc_abs <= cyc_abs + 1;

   int checks = 0;
   int errors = 0;
   logic pay [KL];
   int last_start_abs = -1;
   int done_abs = -1;

   typedef struct {
      logic [7:0]  pay8;
      int          under_idx;
      int          sof_idx;
      logic [23:0] crc;
      bit          eu;
      bit          es;
   } vec_t;
   vec_t tbl [9];

   function automatic logic [23:0] crc_step(input logic [23:0] c, input logic b);
      logic fb;
      fb = c[23] ^ b;
      return {c[22:0], 1'b0} ^ (fb ? POLY : 24'h000000);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string name);
      chk(name, {23'd0, CRC_start, CRC_data, CRC_END, block_size, data_valid,
                 busy, err_underrun, err_sof, in_ready}, 32'd0);
      chk({name, "_state"}, {29'd0, dbg_state}, 32'd0);
   endtask

   // Drives one frame from pay[] and scores the whole output window.
   task automatic run_frame(input bit bs, input int under_idx, input int sof_idx,
                            input bit use_model, input logic [23:0] hand_crc,
                            input bit exp_eu, input bit exp_es, input string tag);
      int k, p, idx, cyc, starts, first_dv, last_dv, dv_cnt, rdy;
      int end_cnt, end_cyc, bs_bad, bit_bad, first_bad, c0_abs;
      logic [23:0] crc, exp_crc, got_crc, rem;
      logic [0:0] exp_q[$];
      logic [0:0] got_q[$];
      logic [0:0] e;
      k = bs ? KL : KS;
      p = k - 24;
      crc = 24'h000000;
      for (int i = 0; i < p; i++) begin
         e = (i == under_idx) ? 1'b0 : pay[i];
         exp_q.push_back(e);
         crc = crc_step(crc, e[0]);
      end
      exp_crc = use_model ? crc : hand_crc;
      for (int j = 23; j >= 0; j--) exp_q.push_back(exp_crc[j]);
      idx = 0; cyc = -1; starts = 0; first_dv = -1; last_dv = -1; dv_cnt = 0;
      rdy = 0; end_cnt = 0; end_cyc = -1; bs_bad = 0; bit_bad = 0;
      first_bad = -1; c0_abs = -1;
      for (int t = 0; t < k + 64; t++) begin
         @(negedge clk);
         if (starts > 0) cyc++;
         if (CRC_start) begin
            starts++;
            if (starts == 1) begin
               cyc = 0;
               c0_abs = cyc_abs;
            end
         end
         if (data_valid) begin
            dv_cnt++;
            if (first_dv < 0) first_dv = cyc;
            last_dv = cyc;
            got_q.push_back(CRC_data);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               if (CRC_data !== e[0]) begin
                  bit_bad++;
                  if (first_bad < 0) first_bad = dv_cnt - 1;
               end
            end else bit_bad++;
         end
         if (CRC_END) begin
            end_cnt++;
            end_cyc = cyc;
         end
         if (in_ready) rdy++;
         if (starts > 0 && (block_size !== bs || busy !== 1'b1)) bs_bad++;
         // a done pulse mid-payload must be ignored
         ilv_done = (rdy == 3);
         if (first_dv >= 0 && !data_valid) break;
         block_size_in = bs;
         if (in_ready && idx < KL) begin
            in_valid = (idx != under_idx);
            in_data  = pay[idx];
            in_sof   = (idx == 0) || (idx == sof_idx);
            idx++;
         end else if (idx < p) begin
            in_valid = 1'b1;
            in_data  = pay[idx];
            in_sof   = (idx == 0);
         end else begin
            in_valid = 1'b0;
            in_data  = 1'b0;
            in_sof   = 1'b0;
         end
      end
      ilv_done = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 1'b0;
      last_start_abs = c0_abs;
      got_crc = 24'hxxxxxx;
      if (got_q.size() == k)
         for (int j = 0; j < 24; j++) got_crc = {got_crc[22:0], got_q[p + j][0]};
      chk({tag, "_start_count"}, starts, 1);
      chk({tag, "_first_valid_cycle"}, first_dv, 2);
      chk({tag, "_last_valid_cycle"}, last_dv, k + 1);
      chk({tag, "_valid_count"}, dv_cnt, k);
      chk({tag, "_ready_count"}, rdy, p);
      chk({tag, "_bit_errors"}, bit_bad, 0);
      if (bit_bad != 0) $display("  %s first bad bit index %0d", tag, first_bad);
      chk({tag, "_parity"}, got_crc, exp_crc);
      chk({tag, "_end_count"}, end_cnt, 1);
      chk({tag, "_end_cycle"}, end_cyc, k + 1);
      chk({tag, "_block_size_busy_held"}, bs_bad, 0);
      chk({tag, "_err_underrun"}, err_underrun, exp_eu);
      chk({tag, "_err_sof"}, err_sof, exp_es);
      if (use_model) begin
         rem = 24'h000000;
         foreach (got_q[j]) rem = crc_step(rem, got_q[j][0]);
         chk({tag, "_remainder"}, rem, 24'h000000);
      end
   endtask

   // Holds in WAIT_DONE, then pulses ilv_done and checks the return to IDLE.
   task automatic end_frame(input bit hold, input logic nb0, input string tag);
      int bad;
      in_valid = hold;
      in_sof = hold;
      in_data = nb0;
      block_size_in = 1'b0;
      ilv_done = 1'b0;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (busy !== 1'b1 || data_valid !== 1'b0 || in_ready !== 1'b0 || CRC_start !== 1'b0)
            bad++;
      end
      chk({tag, "_wait_done_hold"}, bad, 0);
      ilv_done = 1'b1;
      done_abs = cyc_abs;
      @(negedge clk);
      ilv_done = 1'b0;
      chk({tag, "_idle_after_done"}, {busy, CRC_start}, 2'b00);
      if (!hold) begin
         in_valid = 1'b0;
         in_sof = 1'b0;
         in_data = 1'b0;
      end
   endtask

   task automatic load8(input logic [7:0] v);
      for (int i = 0; i < 8; i++) pay[i] = v[7 - i];
   endtask

   initial begin
      tbl[0] = '{8'h80, -1, -1, 24'h3347A4, 1'b0, 1'b0};
      tbl[1] = '{8'h00, -1, -1, 24'h000000, 1'b0, 1'b0};
      tbl[2] = '{8'h01, -1, -1, 24'h864CFB, 1'b0, 1'b0};
      tbl[3] = '{8'h03, -1, -1, 24'h0C99F6, 1'b0, 1'b0};
      tbl[4] = '{8'hA5, -1, -1, 24'h2A3C57, 1'b0, 1'b0};
      tbl[5] = '{8'hFF, -1, -1, 24'hDD8538, 1'b0, 1'b0};
      tbl[6] = '{8'hFF,  3, -1, 24'h18CBB1, 1'b1, 1'b0};
      tbl[7] = '{8'h80, -1,  5, 24'h3347A4, 1'b0, 1'b1};
      tbl[8] = '{8'h40, -1, -1, 24'h19A3D2, 1'b0, 1'b0};

      // reset block
      reset = 1'b1;
      in_valid = 1'b0; in_data = 1'b0; in_sof = 1'b0;
      block_size_in = 1'b0; ilv_done = 1'b0;
      repeat (3) @(negedge clk);
      chk_idle_outputs("reset_outputs");
      reset = 1'b0;
      @(negedge clk);

      // table-driven small frames
      for (int v = 0; v < 9; v++) begin
         load8(tbl[v].pay8);
         run_frame(1'b0, tbl[v].under_idx, tbl[v].sof_idx, 1'b0, tbl[v].crc,
                   tbl[v].eu, tbl[v].es, $sformatf("vec%0d", v));
         end_frame(v == 8, 1'b1, $sformatf("vec%0d", v));
      end

      // next frame's sof was held through WAIT_DONE: start two cycles after done
      load8(8'h80);
      run_frame(1'b0, -1, -1, 1'b0, 24'h3347A4, 1'b0, 1'b0, "held_sof");
      chk("held_sof_start_latency", last_start_abs - done_abs, 2);
      end_frame(1'b0, 1'b0, "held_sof");

      // large block, all zeros
      for (int i = 0; i < KL; i++) pay[i] = 1'b0;
      run_frame(1'b1, -1, -1, 1'b0, 24'h000000, 1'b0, 1'b0, "large_zero");
      end_frame(1'b0, 1'b0, "large_zero");

      // large block, fixed pattern, parity from the software model
      for (int i = 0; i < KL; i++) pay[i] = ((i * 7) ^ (i >> 2) ^ (i >> 5)) & 1;
      run_frame(1'b1, -1, -1, 1'b1, 24'h000000, 1'b0, 1'b0, "large_pattern");
      end_frame(1'b0, 1'b0, "large_pattern");

      // reset in the middle of the payload
      load8(8'h80);
      in_valid = 1'b1; in_sof = 1'b1; in_data = 1'b1; block_size_in = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      chk("mid_reset_ready_seen", in_ready, 1'b1);
      repeat (3) begin
         @(negedge clk);
         in_sof = 1'b0;
         in_data = 1'b0;
      end
      chk("mid_reset_in_payload", {busy, data_valid}, 2'b11);
      reset = 1'b1;
      in_valid = 1'b0;
      #1;
      chk_idle_outputs("mid_reset_outputs");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      run_frame(1'b0, -1, -1, 1'b0, 24'h3347A4, 1'b0, 1'b0, "after_reset");
      end_frame(1'b0, 1'b0, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
